// File: rtl/useq_prog_loader_if.sv
// Byte-serial program load stream between the image source and the loader.
// The source presents a byte with ld_valid; the loader takes it on any clock
// edge where ld_ready is also high.
interface useq_prog_loader_if;
   logic       ld_valid;
   logic [7:0] ld_data;
   logic       ld_ready;

   modport master (
      output ld_valid,
      output ld_data,
      input  ld_ready
   );

   modport slave (
      input  ld_valid,
      input  ld_data,
      output ld_ready
   );
endinterface

// File: rtl/useq_prog_loader.sv
// Program store and boot controller for the useq core.
// Holds the core's byte-wide program RAM, loads it from a valid/ready byte
// stream while the core is kept in reset, then releases the core after a
// fixed hold time. An 8-bit additive checksum of the loaded image is kept.
module useq_prog_loader #(
   parameter int ADDR_W    = 10,
   parameter int MEM_DEPTH = 1024,
   parameter int RST_HOLD  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] core_addr,
   output logic [7:0]        core_data,
   output logic              core_rst_n,
   input  logic              load_start,
   input  logic [ADDR_W:0]   load_len,
   input  logic              restart,
   useq_prog_loader_if.slave ld,
   output logic              busy,
   output logic              running,
   output logic              len_err,
   output logic [7:0]        checksum
);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      HOLD,
      RUN
   } state_t;

   localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(MEM_DEPTH);
   localparam logic [ADDR_W:0] LP_ONE   = (ADDR_W+1)'(1);
   localparam logic [7:0]      LP_HOLD  = 8'(RST_HOLD);

   logic [7:0]      r_mem [0:MEM_DEPTH-1];
   state_t          r_state;
   logic [ADDR_W:0] r_len;
   logic [ADDR_W:0] r_wptr;
   logic [7:0]      r_hold;
   logic [7:0]      r_checksum;
   logic            r_len_err;
   logic            r_ld_ready;
   logic            r_busy;
   logic            r_core_rst_n;
   logic [7:0]      r_core_data;

   logic            w_len_ok;
   logic            w_take_load;
   logic            w_bad_load;
   logic            w_wr;
   logic [ADDR_W:0] w_wptr_next;
   logic            w_last;

   // A length of zero or one beyond the RAM size is rejected; loads are
   // never accepted while a stream is already in progress.
   assign w_len_ok    = (load_len != '0) && (load_len <= LP_DEPTH);
   assign w_take_load = load_start && w_len_ok && (r_state != LOAD);
   assign w_bad_load  = load_start && !w_len_ok && (r_state != LOAD);
   assign w_wr        = (r_state == LOAD) && r_ld_ready && ld.ld_valid;
   assign w_wptr_next = r_wptr + LP_ONE;
   assign w_last      = (w_wptr_next == r_len);

   assign ld.ld_ready = r_ld_ready;
   assign core_data   = r_core_data;
   assign core_rst_n  = r_core_rst_n;
   assign running     = r_core_rst_n;
   assign busy        = r_busy;
   assign len_err     = r_len_err;
   assign checksum    = r_checksum;

   // Program RAM write port; contents survive reset so a partial image stays.
   always_ff @(posedge clk) begin
      if (rst_n && w_wr) begin
         r_mem[r_wptr[ADDR_W-1:0]] <= ld.ld_data;
      end
   end

   // Core read port: one-cycle registered read in every state, old data on collision.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_core_data <= 8'h00;
      end else begin
         r_core_data <= r_mem[core_addr];
      end
   end

   // Boot sequencer: load the image, hold the core in reset, then let it run.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_len        <= '0;
         r_wptr       <= '0;
         r_hold       <= 8'h00;
         r_checksum   <= 8'h00;
         r_len_err    <= 1'b0;
         r_ld_ready   <= 1'b0;
         r_busy       <= 1'b0;
         r_core_rst_n <= 1'b0;
      end else if (w_take_load) begin
         r_state      <= LOAD;
         r_len        <= load_len;
         r_wptr       <= '0;
         r_checksum   <= 8'h00;
         r_len_err    <= 1'b0;
         r_ld_ready   <= 1'b1;
         r_busy       <= 1'b1;
         r_core_rst_n <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_bad_load) begin
                  r_len_err <= 1'b1;
               end
            end
            LOAD: begin
               if (w_wr) begin
                  r_wptr     <= w_wptr_next;
                  r_checksum <= r_checksum + ld.ld_data;
                  if (w_last) begin
                     r_state    <= HOLD;
                     r_hold     <= LP_HOLD;
                     r_ld_ready <= 1'b0;
                  end
               end
            end
            HOLD: begin
               if (w_bad_load) begin
                  r_len_err <= 1'b1;
               end
               if (restart) begin
                  r_hold <= LP_HOLD;
               end else if (r_hold == 8'd1) begin
                  r_state      <= RUN;
                  r_busy       <= 1'b0;
                  r_core_rst_n <= 1'b1;
               end else begin
                  r_hold <= r_hold - 8'd1;
               end
            end
            RUN: begin
               if (w_bad_load) begin
                  r_len_err <= 1'b1;
               end
               if (restart) begin
                  r_state      <= HOLD;
                  r_hold       <= LP_HOLD;
                  r_busy       <= 1'b1;
                  r_core_rst_n <= 1'b0;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule
